adc_scan_pwm: RTL and testbench
===============================

# adc_scan_pwm

Parametrised ADC channel scanner and PWM driver. It round-robins the ADC dynamic-reconfiguration (DRP) read port over N_CH auxiliary channels and keeps the top DATA_W bits of each result. Each result passes through an optional per-channel exponential smoothing filter and drives one PWM output per channel. It sits between the XADC wizard instance and the board LEDs/test pins, replacing the fixed 4-channel inline logic in the top level.

## Interface
- N_CH, 4, number of scanned channels, 1..8
- DATA_W, 8, kept result bits (dout[15 -: DATA_W]) and PWM resolution, 4..12
- AVG_LOG2, 2, smoothing shift k; 0 = filter bypassed
- CH_ADDR, {8{7'h1E}} packed 8×7 bits, DRP address of channel i at bits [7i+6:7i]
- TIMEOUT, 255, max cycles waiting for drdy before abandoning a read
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- eoc_in  in  1  ADC end-of-conversion pulse
- drdy_in  in  1  DRP data-ready
- do_in  in  16  DRP read data
- den  out  1  DRP enable, one-cycle pulse
- daddr  out  7  DRP address, held stable from den until drdy or timeout
- pwm  out  N_CH  PWM outputs, one per channel
- sample_valid  out  1  one-cycle strobe, new filtered value
- sample_ch  out  max(1,$clog2(N_CH))  channel of current sample
- sample_data  out  DATA_W  filtered value of sample_ch
- err_timeout  out  1  sticky, set on any drdy timeout, cleared only by rst

## Operation
- FSM states: IDLE, REQ, WAIT, STORE.
- IDLE: eoc_in=1 -> REQ. daddr is driven from CH_ADDR[ch_idx] at all times.
- REQ: den=1 for exactly this cycle -> WAIT. Timeout counter cleared.
- WAIT, drdy_in=1: raw <= do_in[15 -: DATA_W] -> STORE.
- WAIT, counter reaches TIMEOUT with no drdy: err_timeout <= 1, ch_idx advances, filter state untouched -> IDLE.
- STORE: filt[ch] updated, sample_valid/sample_ch/sample_data registered, ch_idx <= (ch_idx==N_CH-1) ? 0 : ch_idx+1 -> IDLE.
- eoc_in outside IDLE is ignored; no queueing.
- Filter: filt <= filt + ((raw - filt) >>> AVG_LOG2), signed arithmetic at DATA_W+1 bits, result truncated to DATA_W. It never overflows because the result lies between filt and raw. AVG_LOG2=0 gives filt=raw.
- PWM: one shared DATA_W-bit free-running counter, wraps 2^DATA_W-1 -> 0. duty[i] <= filt[i] only when counter==0. pwm[i] = (counter < duty[i]).
  - duty 0 = constant low; duty max = high 2^DATA_W-1 of every 2^DATA_W cycles.

## Timing
- Reset values: state IDLE, ch_idx 0, den 0, daddr CH_ADDR[0], pwm all 0, sample_valid 0, sample_ch 0, sample_data 0, err_timeout 0, filt/duty/counter 0.
- eoc_in high at edge t -> den high during cycle t+1.
- drdy_in high at edge d -> sample_valid high during cycle d+2, exactly one cycle.
- Read latency from eoc to sample_valid = DRP latency + 3 cycles.
- Duty change takes effect at the next counter wrap, so worst-case latency is 2^DATA_W cycles and no glitch occurs within a PWM period.
- drdy_in outside WAIT is ignored.
- rst asserted mid-read aborts immediately: den drops asynchronously and nothing is stored.
- With N_CH=1, ch_idx is constant 0.

## Structure
- Package adc_scan_pkg holds: state enum (IDLE/REQ/WAIT/STORE), the sample_ch width function, and the default CH_ADDR constant for the Zybo JXADC map (1E,17,1F,16).
- One sub-module: pwm_gen (shared counter input, duty latch at wrap, compare), generated N_CH times. The counter lives in the parent.

## Test plan
- Reset: after rst, all outputs at reset values; first eoc_in reads address CH_ADDR[0].
- Scan order: N_CH=4, AVG_LOG2=0, 8 eoc/drdy cycles with do_in=16'hAB00 -> sample_ch sequence 0,1,2,3,0,1,2,3; sample_data=8'hAB; daddr sequence 1E,17,1F,16.
- Filter: AVG_LOG2=2, one channel, repeated raw 8'h80 from 0 -> sample_data 0x20, 0x38, 0x4A, 0x57...; then raw 0 -> output decreases monotonically to 0.
- Timeout: TIMEOUT=10, withhold drdy -> err_timeout=1 at cycle 11 after den; next eoc reads the next channel; late drdy_in ignored.
- PWM: DATA_W=4, duty 0/5/15 -> high 0/5/15 of each 16 cycles; duty change mid-period applies only after wrap.
- Async reset during WAIT: den/sample_valid 0 immediately, no sample_valid afterwards until a new eoc.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADC channel scanner / PWM driver.
package adc_scan_pkg;

  // Scanner sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } scan_state_e;

  // Zybo JXADC auxiliary-channel map: ch0..ch3 = 1E,17,1F,16, rest parked on 1E.
  localparam logic [55:0] ZYBO_CH_ADDR = {7'h1E, 7'h1E, 7'h1E, 7'h1E,
                                          7'h16, 7'h1F, 7'h17, 7'h1E};

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// One PWM channel: latches its duty when the shared counter is at zero and
// compares the counter against it, so a new level only starts on a period boundary.
module pwm_gen #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cnt_i,
  input  logic [DATA_W-1:0] level_i,
  output logic              pwm_o
);

  logic [DATA_W-1:0] duty_q;
  logic [DATA_W-1:0] duty_d;
  logic              pwm_q;
  logic              pwm_d;

  // Duty only follows the filtered level at the start of a period.
  always_comb begin
    duty_d = (cnt_i == '0) ? level_i : duty_q;
    pwm_d  = (cnt_i < duty_d);
  end

  // Duty latch and registered compare output (glitch-free pin).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/adc_scan_pwm.sv
// Round-robin DRP reader over N_CH ADC channels with per-channel exponential
// smoothing, a sample strobe for downstream logic, and one PWM output per channel.
module adc_scan_pwm
  import adc_scan_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          DATA_W   = 8,
  parameter int          AVG_LOG2 = 2,
  parameter logic [55:0] CH_ADDR  = {8{7'h1E}},
  parameter int          TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eoc_in,
  input  logic                     drdy_in,
  input  logic [15:0]              do_in,
  output logic                     den,
  output logic [6:0]               daddr,
  output logic [N_CH-1:0]          pwm,
  output logic                     sample_valid,
  output logic [ch_w(N_CH)-1:0]    sample_ch,
  output logic [DATA_W-1:0]        sample_data,
  output logic                     err_timeout
);

  localparam int CH_W = ch_w(N_CH);
  // The wait counter only ever reaches TIMEOUT-1.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  scan_state_e       state_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ch_adv;
  logic              den_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [DATA_W-1:0] raw_q;
  logic              err_q;
  logic              sv_q;
  logic [CH_W-1:0]   sch_q;
  logic [DATA_W-1:0] sdata_q;
  logic [DATA_W-1:0] filt_q [N_CH];
  logic [DATA_W-1:0] filt_cur;
  logic [DATA_W-1:0] filt_d;
  logic [6:0]        daddr_sel;
  logic [DATA_W-1:0] pwm_cnt_q;

  // Only the top DATA_W bits of the DRP word carry the kept result.
  logic unused_low_bits;
  assign unused_low_bits = ^do_in[15-DATA_W:0];

  // One smoothing step: cur + ((raw - cur) >>> AVG_LOG2) in DATA_W+1 signed bits.
  // The result always lies between cur and raw, so truncation never wraps.
  function automatic logic [DATA_W-1:0] smooth_step(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] raw);
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] sum;
    diff = $signed({1'b0, raw}) - $signed({1'b0, cur});
    sum  = $signed({1'b0, cur}) + (diff >>> AVG_LOG2);
    return sum[DATA_W-1:0];
  endfunction

  // Decode the current channel into its filter state and DRP address.
  always_comb begin
    filt_cur  = '0;
    daddr_sel = CH_ADDR[6:0];
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        filt_cur  = filt_q[i];
        daddr_sel = CH_ADDR[7*i +: 7];
      end
    end
  end

  // Next channel in round-robin order and the smoothed value for the current one.
  always_comb begin
    ch_adv = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
    filt_d = smooth_step(filt_cur, raw_q);
  end

  // Scan sequencer: request, wait for data or give up, then publish the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      den_q    <= 1'b0;
      to_cnt_q <= '0;
      raw_q    <= '0;
      err_q    <= 1'b0;
      sv_q     <= 1'b0;
      sch_q    <= '0;
      sdata_q  <= '0;
    end else begin
      den_q <= 1'b0;
      sv_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (eoc_in) begin
            den_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          to_cnt_q <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (drdy_in) begin
            raw_q   <= do_in[15 -: DATA_W];
            state_q <= STORE;
          end else if (to_cnt_q == TO_LAST) begin
            // Abandon this channel; its filter state keeps the previous value.
            err_q   <= 1'b1;
            ch_q    <= ch_adv;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        STORE: begin
          sv_q    <= 1'b1;
          sch_q   <= ch_q;
          sdata_q <= filt_d;
          ch_q    <= ch_adv;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-channel filter state, written once per completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) filt_q[i] <= '0;
    end else if (state_q == STORE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_q == CH_W'(i)) filt_q[i] <= filt_d;
      end
    end
  end

  // Shared free-running PWM period counter; wraps naturally at 2^DATA_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_q + DATA_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pwm
    pwm_gen #(
      .DATA_W (DATA_W)
    ) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .cnt_i   (pwm_cnt_q),
      .level_i (filt_q[g]),
      .pwm_o   (pwm[g])
    );
  end

  assign den          = den_q;
  assign daddr        = daddr_sel;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign sample_data  = sdata_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_adc_scan_pwm.sv
// Bench for adc_scan_pwm: two instances share one stimulus stream.
//  A: 4 channels, 8-bit, no smoothing, Zybo address map.
//  B: 1 channel, 4-bit, smoothing shift 2.
// Expected samples, addresses, errors and PWM high-times come from a
// per-transaction model of the channel rotation and the smoothing formula.
module tb_adc_scan_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eoc_in = 1'b0;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = '0;

  logic       den_a, sv_a, err_a;
  logic [6:0] daddr_a;
  logic [3:0] pwm_a;
  logic [1:0] sch_a;
  logic [7:0] sd_a;

  logic       den_b, sv_b, err_b;
  logic [6:0] daddr_b;
  logic [0:0] pwm_b;
  logic [0:0] sch_b;
  logic [3:0] sd_b;

  always #5 clk = ~clk;

  adc_scan_pwm #(
    .N_CH(4), .DATA_W(8), .AVG_LOG2(0),
    .CH_ADDR({7'h1E, 7'h1E, 7'h1E, 7'h1E, 7'h16, 7'h1F, 7'h17, 7'h1E}),
    .TIMEOUT(10)
  ) dut_a (
    .clk(clk), .rst(rst), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
    .den(den_a), .daddr(daddr_a), .pwm(pwm_a), .sample_valid(sv_a),
    .sample_ch(sch_a), .sample_data(sd_a), .err_timeout(err_a)
  );

  adc_scan_pwm #(
    .N_CH(1), .DATA_W(4), .AVG_LOG2(2),
    .CH_ADDR({8{7'h05}}),
    .TIMEOUT(10)
  ) dut_b (
    .clk(clk), .rst(rst), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
    .den(den_b), .daddr(daddr_b), .pwm(pwm_b), .sample_valid(sv_b),
    .sample_ch(sch_b), .sample_data(sd_b), .err_timeout(err_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int addr_a [4] = '{'h1E, 'h17, 'h1F, 'h16};
  int mch;
  int mfilt_a [4];
  int mfilt_b;
  int merr;
  int n_edge;
  int duty_a [4];
  int hi_a [4];
  int duty_b;
  int hi_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Exponential smoothing with floor division: cur + floor((raw-cur)/2^k).
  function automatic int smooth(input int cur, input int raw, input int k);
    int d;
    int div;
    d   = raw - cur;
    div = 1 << k;
    if (d >= 0) return cur + d / div;
    return cur - ((-d + div - 1) / div);
  endfunction

  task automatic model_reset();
    mch = 0;
    merr = 0;
    mfilt_b = 0;
    duty_b = 0;
    hi_b = 0;
    for (int i = 0; i < 4; i++) begin
      mfilt_a[i] = 0;
      duty_a[i] = 0;
      hi_a[i] = 0;
    end
    n_edge = -1;
  endtask

  // Advance one clock and account PWM high time per period. A period starts at
  // every edge where the DUT counter was zero; its duty is the filtered level
  // known at that moment, and the number of high cycles must equal that duty.
  task automatic step();
    @(posedge clk);
    #1;
    n_edge++;
    if (n_edge % 16 == 0) begin
      if (n_edge > 0) chk("pwm_b_period", hi_b, duty_b);
      duty_b = mfilt_b;
      hi_b = 0;
    end
    if (n_edge % 256 == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (n_edge > 0) chk($sformatf("pwm_a%0d_period", i), hi_a[i], duty_a[i]);
        duty_a[i] = mfilt_a[i];
        hi_a[i] = 0;
      end
    end
    hi_b += int'(pwm_b[0]);
    for (int i = 0; i < 4; i++) hi_a[i] += int'(pwm_a[i]);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs();
    chk("rst_den_a", den_a, 0);
    chk("rst_den_b", den_b, 0);
    chk("rst_daddr_a", daddr_a, 'h1E);
    chk("rst_daddr_b", daddr_b, 'h05);
    chk("rst_pwm_a", pwm_a, 0);
    chk("rst_pwm_b", pwm_b, 0);
    chk("rst_sv_a", sv_a, 0);
    chk("rst_sv_b", sv_b, 0);
    chk("rst_sch_a", sch_a, 0);
    chk("rst_sd_a", sd_a, 0);
    chk("rst_sd_b", sd_b, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_err_b", err_b, 0);
  endtask

  // Idle cycles with random stray drdy pulses, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drdy_in = 1'($urandom_range(0, 1));
      do_in = 16'($urandom);
      step();
      chk("idle_sv_a", sv_a, 0);
      chk("idle_sv_b", sv_b, 0);
    end
    drdy_in = 1'b0;
  endtask

  // One eoc-triggered read. lat = edges from entering WAIT to drdy (1..10);
  // to = withhold drdy and let the read time out.
  task automatic do_read(input int lat, input logic [15:0] d, input bit to);
    eoc_in = 1'b1;
    step();
    chk("den_pulse_a", den_a, 1);
    chk("den_pulse_b", den_b, 1);
    chk("daddr_a", daddr_a, addr_a[mch]);
    chk("daddr_b", daddr_b, 'h05);
    eoc_in = 1'b0;
    step();
    chk("den_drop_a", den_a, 0);
    chk("den_drop_b", den_b, 0);
    if (!to) begin
      for (int j = 1; j < lat; j++) begin
        eoc_in = 1'($urandom_range(0, 1));
        step();
        chk("daddr_hold_a", daddr_a, addr_a[mch]);
        chk("wait_sv_a", sv_a, 0);
      end
      eoc_in = 1'b0;
      drdy_in = 1'b1;
      do_in = d;
      step();
      drdy_in = 1'b0;
      do_in = 16'($urandom);
      chk("sv_early_a", sv_a, 0);
      chk("sv_early_b", sv_b, 0);
      step();
      mfilt_a[mch] = smooth(mfilt_a[mch], int'(d[15:8]), 0);
      mfilt_b = smooth(mfilt_b, int'(d[15:12]), 2);
      chk("sv_a", sv_a, 1);
      chk("sv_b", sv_b, 1);
      chk("sample_ch_a", sch_a, mch);
      chk("sample_ch_b", sch_b, 0);
      chk("sample_data_a", sd_a, mfilt_a[mch]);
      chk("sample_data_b", sd_b, mfilt_b);
      chk("err_hold_a", err_a, merr);
      mch = (mch + 1) % 4;
      step();
      chk("sv_one_cycle_a", sv_a, 0);
      chk("sv_one_cycle_b", sv_b, 0);
    end else begin
      // Den was cycle 0; the counter expires so err shows in cycle 11.
      for (int j = 1; j <= 9; j++) begin
        eoc_in = 1'($urandom_range(0, 1));
        step();
        chk("err_before_to_a", err_a, merr);
        chk("err_before_to_b", err_b, merr);
      end
      step();
      merr = 1;
      chk("err_timeout_a", err_a, 1);
      chk("err_timeout_b", err_b, 1);
      mch = (mch + 1) % 4;
      eoc_in = 1'b0;
      drdy_in = 1'b1;
      do_in = 16'($urandom);
      for (int j = 0; j < 3; j++) begin
        step();
        drdy_in = 1'b0;
        chk("late_drdy_sv_a", sv_a, 0);
        chk("late_drdy_sv_b", sv_b, 0);
      end
    end
  endtask

  // Reset asserted while den is high: den must drop without waiting for a clock.
  task automatic abort_in_req();
    eoc_in = 1'b1;
    step();
    eoc_in = 1'b0;
    chk("abort_den_before", den_a, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_den_a", den_a, 0);
    chk("abort_den_b", den_b, 0);
    chk("abort_sv_a", sv_a, 0);
    release_rst();
    chk("abort_err_clr", err_a, 0);
  endtask

  // Reset asserted after data was accepted: the sample must never appear.
  task automatic abort_in_store();
    eoc_in = 1'b1;
    step();
    eoc_in = 1'b0;
    step();
    drdy_in = 1'b1;
    do_in = 16'hF000;
    step();
    drdy_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_store_sv_a", sv_a, 0);
    chk("abort_store_sv_b", sv_b, 0);
    release_rst();
    chk("abort_store_pwm_a", pwm_a, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] rd;
    model_reset();
    #23;
    check_reset_outputs();
    release_rst();
    idle(3);

    // Scan order with a constant word: 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 8; r++) do_read($urandom_range(1, 10), 16'hAB00, 1'b0);

    // Smoothed channel rising toward a constant input, then decaying to 0.
    for (int r = 0; r < 6; r++) do_read($urandom_range(1, 10), 16'h8000, 1'b0);
    for (int r = 0; r < 10; r++) do_read($urandom_range(1, 10), 16'h0000, 1'b0);
    chk("filt_floor_b", sd_b, 0);

    // Timeout, then the next read must address the following channel.
    do_read(0, 16'h0000, 1'b1);
    do_read($urandom_range(1, 10), 16'h1200, 1'b0);

    // Full-scale duty on every channel of A, then whole PWM periods.
    for (int r = 0; r < 4; r++) do_read($urandom_range(1, 10), 16'hFF00, 1'b0);
    idle(600);

    // Random traffic with occasional timeouts.
    for (int r = 0; r < 40; r++) begin
      rd = 16'($urandom);
      do_read($urandom_range(1, 10), rd, ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 3));
    end
    idle(300);

    abort_in_req();
    idle(5);
    do_read($urandom_range(1, 10), 16'h5A00, 1'b0);
    abort_in_store();
    idle(5);
    do_read($urandom_range(1, 10), 16'h3C00, 1'b0);
    idle(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
